// File: rtl/mq_llfifo_pkg.sv
// mq_llfifo_pkg: shared defaults, pointer/count types and per-queue record for mq_llfifo.
`default_nettype none
package mq_llfifo_pkg;
  localparam int ID_N_DEF  = 4;
  localparam int PTR_N_DEF = 256;
  localparam int W_DEF     = 32;
  localparam int ID_W      = $clog2(ID_N_DEF);
  localparam int PTR_W     = $clog2(PTR_N_DEF);
  localparam int CNT_W     = $clog2(PTR_N_DEF + 1);

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    ptr_t head;
    ptr_t tail;
    cnt_t cnt;
  } queue_t;
endpackage
`default_nettype wire

// File: rtl/mq_llfifo_alloc.sv
// mq_llfifo_alloc: free-entry bitmap with lowest-index allocation and a running free count.
`default_nettype none
module mq_llfifo_alloc #(
  parameter int PTR_N = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc,
  output logic [$clog2(PTR_N)-1:0]     alloc_idx,
  input  logic                         rel_vld,
  input  logic [$clog2(PTR_N)-1:0]     rel_idx,
  output logic [$clog2(PTR_N+1)-1:0]   free_cnt
);
  localparam int PW = $clog2(PTR_N);
  localparam int CW = $clog2(PTR_N + 1);

  logic [PTR_N-1:0] free_q;

  // Allocation looks only at the registered bitmap, so an entry released
  // this cycle cannot be handed out again until the next one.
  always_comb begin
    alloc_idx = '0;
    for (int i = PTR_N - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_idx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_q   <= '1;
      free_cnt <= CW'(PTR_N);
    end else begin
      if (alloc)   free_q[alloc_idx] <= 1'b0;
      if (rel_vld) free_q[rel_idx]   <= 1'b1;
      free_cnt <= free_cnt - CW'(alloc) + CW'(rel_vld);
    end
  end
endmodule
`default_nettype wire

// File: rtl/mq_llfifo.sv
// mq_llfifo: ID_N FIFO queues sharing PTR_N entries through linked lists.
`default_nettype none
module mq_llfifo
  import mq_llfifo_pkg::*;
#(
  parameter int ID_N  = ID_N_DEF,
  parameter int PTR_N = PTR_N_DEF,
  parameter int W     = W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_vld,
  input  logic [$clog2(ID_N)-1:0]      push_id,
  input  logic [W-1:0]                 push_data,
  output logic                         push_rdy,
  input  logic                         pop_vld,
  input  logic [$clog2(ID_N)-1:0]      pop_id,
  output logic                         rsp_vld,
  output logic [$clog2(ID_N)-1:0]      rsp_id,
  output logic [W-1:0]                 rsp_data,
  output logic [ID_N-1:0]              empty,
  output logic [$clog2(PTR_N+1)-1:0]   free_cnt,
  output logic                         pop_err
);
  localparam int IDW = $clog2(ID_N);
  localparam int PW  = $clog2(PTR_N);
  localparam int CW  = $clog2(PTR_N + 1);

  logic [W-1:0]  data_mem [PTR_N];
  logic [PW-1:0] next_mem [PTR_N];
  logic [PW-1:0] head_q   [ID_N];
  logic [PW-1:0] tail_q   [ID_N];
  logic [CW-1:0] cnt_q    [ID_N];

  logic          push_acc;
  logic          pop_acc;
  logic          push_fresh;
  logic [PW-1:0] alloc_idx;
  logic [PW-1:0] pop_ptr;

  always_comb begin
    for (int i = 0; i < ID_N; i++) empty[i] = (cnt_q[i] == '0);
  end

  // push_rdy depends only on registered state, never on this cycle's pop.
  assign push_rdy = (free_cnt != '0);
  assign push_acc = push_vld & push_rdy;
  assign pop_acc  = pop_vld & ~empty[pop_id];
  assign pop_ptr  = head_q[pop_id];

  // The new entry starts a fresh list when the queue is empty, or when the
  // only entry it holds is leaving in this same cycle.
  assign push_fresh = (cnt_q[push_id] == '0) ||
                      (pop_acc && (pop_id == push_id) && (cnt_q[push_id] == CW'(1)));

  mq_llfifo_alloc #(.PTR_N(PTR_N)) u_alloc (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (push_acc),
    .alloc_idx (alloc_idx),
    .rel_vld   (pop_acc),
    .rel_idx   (pop_ptr),
    .free_cnt  (free_cnt)
  );

  always_ff @(posedge clk) begin
    if (push_acc) begin
      data_mem[alloc_idx] <= push_data;
      if (cnt_q[push_id] != '0) next_mem[tail_q[push_id]] <= alloc_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ID_N; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
      pop_err  <= 1'b0;
    end else begin
      rsp_vld <= pop_acc;
      pop_err <= pop_vld & empty[pop_id];
      if (pop_acc) begin
        rsp_id              <= pop_id;
        rsp_data            <= data_mem[pop_ptr];
        head_q[pop_id]      <= next_mem[pop_ptr];
      end
      // Placed after the pop update so a fresh list head wins on the same queue.
      if (push_acc) begin
        tail_q[push_id] <= alloc_idx;
        if (push_fresh) head_q[push_id] <= alloc_idx;
      end
      for (int i = 0; i < ID_N; i++) begin
        cnt_q[i] <= cnt_q[i]
                  + CW'(push_acc && (push_id == IDW'(i)))
                  - CW'(pop_acc  && (pop_id  == IDW'(i)));
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mq_llfifo.sv
// tb_mq_llfifo: directed vector table, hand-written corner sequences and random traffic against a queue model.
`default_nettype none
module tb_mq_llfifo;
  localparam int ID_N  = 4;
  localparam int PTR_N = 8;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_vld;
  logic [1:0]    push_id;
  logic [W-1:0]  push_data;
  logic          push_rdy;
  logic          pop_vld;
  logic [1:0]    pop_id;
  logic          rsp_vld;
  logic [1:0]    rsp_id;
  logic [W-1:0]  rsp_data;
  logic [3:0]    empty;
  logic [3:0]    free_cnt;
  logic          pop_err;

  always #5 clk = ~clk;

  mq_llfifo #(.ID_N(ID_N), .PTR_N(PTR_N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_vld(push_vld), .push_id(push_id), .push_data(push_data), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_id(pop_id),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .empty(empty), .free_cnt(free_cnt), .pop_err(pop_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one plain queue of words per queue id.
  logic [W-1:0] mq [ID_N][$];
  logic [W-1:0] m_rsp_data;
  logic [1:0]   m_rsp_id;
  bit           m_rsp_vld;
  bit           m_err;

  typedef struct {
    bit          pv;
    int          pid;
    logic [31:0] pd;
    bit          ov;
    int          oid;
    bit          e_vld;
    logic [31:0] e_data;
    logic [3:0]  e_empty;
    int          e_free;
    bit          e_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_total();
    int t = 0;
    for (int i = 0; i < ID_N; i++) t += mq[i].size();
    return t;
  endfunction

  function automatic logic [3:0] m_empty();
    logic [3:0] e;
    for (int i = 0; i < ID_N; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  task automatic check_model();
    chk("rsp_vld", 64'(rsp_vld), 64'(m_rsp_vld));
    chk("pop_err", 64'(pop_err), 64'(m_err));
    chk("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
    chk("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
    chk("empty", 64'(empty), 64'(m_empty()));
    chk("free_cnt", 64'(free_cnt), 64'(PTR_N - m_total()));
    chk("push_rdy", 64'(push_rdy), 64'(m_total() < PTR_N));
  endtask

  task automatic step(input bit pv, input int pid, input logic [W-1:0] pd, input bit ov, input int oid);
    bit pacc, oacc;
    push_vld = pv; push_id = 2'(pid); push_data = pd;
    pop_vld = ov;  pop_id = 2'(oid);
    pacc = pv && (m_total() < PTR_N);
    oacc = ov && (mq[oid].size() != 0);
    @(posedge clk); #1;
    m_rsp_vld = oacc;
    m_err     = ov && !oacc;
    if (oacc) begin
      m_rsp_data = mq[oid].pop_front();
      m_rsp_id   = 2'(oid);
    end
    if (pacc) mq[pid].push_back(pd);
    push_vld = 1'b0; pop_vld = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_vld = 1'b1; push_id = 2'd1; push_data = 32'hDEAD;
    pop_vld = 1'b1;  pop_id = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; push_vld = 1'b0; pop_vld = 1'b0;
    for (int i = 0; i < ID_N; i++) mq[i].delete();
    m_rsp_data = '0; m_rsp_id = '0; m_rsp_vld = 1'b0; m_err = 1'b0;
    chk("rst_free_cnt", 64'(free_cnt), 64'(PTR_N));
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    chk("rst_pop_err", 64'(pop_err), 64'h0);
    chk("rst_push_rdy", 64'(push_rdy), 64'h1);
  endtask

  initial begin
    rst_n = 1'b0; push_vld = 1'b0; push_id = '0; push_data = '0; pop_vld = 1'b0; pop_id = '0;

    //                pv pid pd        ov oid  vld data      empty    free err
    tbl[0]  = '{1, 0, 32'hA,   0, 0, 0, 32'h0,   4'b1110, 7, 0};
    tbl[1]  = '{1, 0, 32'hB,   0, 0, 0, 32'h0,   4'b1110, 6, 0};
    tbl[2]  = '{1, 0, 32'hC,   0, 0, 0, 32'h0,   4'b1110, 5, 0};
    tbl[3]  = '{0, 0, 32'h0,   1, 0, 1, 32'hA,   4'b1110, 6, 0};
    tbl[4]  = '{0, 0, 32'h0,   1, 0, 1, 32'hB,   4'b1110, 7, 0};
    tbl[5]  = '{0, 0, 32'h0,   1, 0, 1, 32'hC,   4'b1111, 8, 0};
    tbl[6]  = '{0, 0, 32'h0,   1, 3, 0, 32'hC,   4'b1111, 8, 1};
    tbl[7]  = '{0, 0, 32'h0,   0, 0, 0, 32'hC,   4'b1111, 8, 0};
    tbl[8]  = '{1, 2, 32'h5,   0, 0, 0, 32'hC,   4'b1011, 7, 0};
    tbl[9]  = '{1, 2, 32'h6,   1, 2, 1, 32'h5,   4'b1011, 7, 0};
    tbl[10] = '{0, 0, 32'h0,   1, 2, 1, 32'h6,   4'b1111, 8, 0};
    tbl[11] = '{1, 1, 32'h11,  1, 1, 0, 32'h6,   4'b1101, 7, 1};
    tbl[12] = '{0, 0, 32'h0,   1, 1, 1, 32'h11,  4'b1111, 8, 0};

    @(posedge clk); #1;
    do_reset();

    foreach (tbl[k]) begin
      step(tbl[k].pv, tbl[k].pid, tbl[k].pd, tbl[k].ov, tbl[k].oid);
      chk($sformatf("vec%0d_rsp_vld", k), 64'(rsp_vld), 64'(tbl[k].e_vld));
      chk($sformatf("vec%0d_rsp_data", k), 64'(rsp_data), 64'(tbl[k].e_data));
      chk($sformatf("vec%0d_empty", k), 64'(empty), 64'(tbl[k].e_empty));
      chk($sformatf("vec%0d_free_cnt", k), 64'(free_cnt), 64'(tbl[k].e_free));
      chk($sformatf("vec%0d_pop_err", k), 64'(pop_err), 64'(tbl[k].e_err));
    end

    // Fill all entries across q1/q2, then a dropped push, then pop/push reuse.
    for (int i = 0; i < PTR_N; i++) step(1, 1 + (i % 2), 32'h100 + i, 0, 0);
    chk("full_push_rdy", 64'(push_rdy), 64'h0);
    chk("full_free_cnt", 64'(free_cnt), 64'h0);
    step(1, 3, 32'hBAD, 0, 0);
    chk("drop_empty3", 64'(empty[3]), 64'h1);
    chk("drop_free_cnt", 64'(free_cnt), 64'h0);
    step(1, 3, 32'hBAD2, 1, 1);
    chk("nobypass_rsp", 64'(rsp_data), 64'h100);
    chk("nobypass_free", 64'(free_cnt), 64'h1);
    chk("nobypass_empty3", 64'(empty[3]), 64'h1);
    step(1, 3, 32'h77, 0, 0);
    chk("reuse_free", 64'(free_cnt), 64'h0);
    step(0, 0, 0, 1, 3);
    chk("reuse_rsp", 64'(rsp_data), 64'h77);
    while (m_total() != 0) begin
      for (int q = 1; q < 3; q++) if (mq[q].size() != 0) step(0, 0, 0, 1, q);
    end

    // Reset with five entries queued.
    for (int i = 0; i < 5; i++) step(1, i % 4, 32'h200 + i, 0, 0);
    chk("prerst_free", 64'(free_cnt), 64'h3);
    do_reset();

    // Random traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55, int'($urandom_range(0, 3)), $urandom,
             $urandom_range(0, 99) < 45, int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mq_llfifo.md
MQ_LLFIFO -- requirements
Module: mq_llfifo

Interface
REQ-001 SHALL have parameter ID_N, default 4, number of independent queues.
REQ-002 SHALL have parameter PTR_N, default 256, total shared entries across all queues.
REQ-003 SHALL have parameter W, default 32, data word width.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 push_vld  in  1  push request.
REQ-007 push_id  in  $clog2(ID_N)  target queue of push.
REQ-008 push_data  in  W  word to enqueue.
REQ-009 push_rdy  out  1  shared storage not full (free_cnt != 0).
REQ-010 pop_vld  in  1  pop request.
REQ-011 pop_id  in  $clog2(ID_N)  source queue of pop.
REQ-012 rsp_vld  out  1  pop response valid.
REQ-013 rsp_id  out  $clog2(ID_N)  queue of returned word.
REQ-014 rsp_data  out  W  popped word.
REQ-015 empty  out  ID_N  per-queue empty flags, bit i = queue i.
REQ-016 free_cnt  out  $clog2(PTR_N+1)  unallocated entries.
REQ-017 pop_err  out  1  one-cycle pulse, pop to empty queue.

Function
REQ-018 Storage: data array PTR_N x W, next-pointer array PTR_N x PTR_W, per-queue {head, tail, cnt}, free bitmap PTR_N bits.
REQ-019 Push accepted iff push_vld & push_rdy; allocates lowest-index free entry, writes data, links it after current tail.
REQ-020 Push to empty queue: head = tail = allocated entry; otherwise next[tail] = entry, tail = entry.
REQ-021 Push with push_rdy=0 SHALL be dropped, no state change; no same-cycle pop bypass into push_rdy.
REQ-022 Pop accepted iff pop_vld & ~empty[pop_id] (registered flag); head entry freed, head = next[head].
REQ-023 Pop response latency exactly 1 cycle: rsp_vld, rsp_id, rsp_data registered from accepted pop.
REQ-024 rsp_vld low in cycles with no accepted pop; rsp_data holds last value.
REQ-025 Pop to empty queue: no state change, pop_err high next cycle, rsp_vld low.
REQ-026 Push and pop same cycle, different queues: both proceed independently.
REQ-027 Push and pop same cycle, same queue, cnt==1: popped entry freed; head = tail = new entry.
REQ-028 Push and pop same cycle, same queue, cnt==0: push proceeds, pop rejected with pop_err.
REQ-029 Freed entry SHALL NOT be reallocated in same cycle it is freed; available from next cycle.
REQ-030 free_cnt next = free_cnt - push_acc + pop_acc; per-queue cnt likewise; never underflow/overflow.
REQ-031 empty[i] = (cnt[i]==0), registered.
REQ-032 Per-queue order strictly FIFO; queues never interleave data.

Reset
REQ-033 On rst_n low at clk edge: all entries free, free_cnt=PTR_N, empty all ones, cnt zero, push_rdy=1.
REQ-034 Reset: rsp_vld=0, rsp_id=0, rsp_data=0, pop_err=0.
REQ-035 Reset mid-operation discards all queued data; requests in the reset cycle ignored.
REQ-036 Data and next arrays need no reset.

Structure
REQ-037 Shared package holds ID_N/PTR_N/W defaults, PTR_W, id_t, ptr_t, cnt_t, queue_t {head, tail, cnt}.
REQ-038 Sub-module mq_llfifo_alloc: free bitmap, lowest-index priority encoder, free_cnt, alloc/release ports.
REQ-039 No combinational path from pop_vld to push_rdy, or from inputs to rsp_*.

Verification (ID_N=4, PTR_N=8, W=32)
REQ-040 Reset, push q0 0xA, 0xB, 0xC -> entries 0,1,2 used, free_cnt=5, empty=4'b1110.
REQ-041 Then pop q0 three times -> rsp 0xA, 0xB, 0xC one cycle after each pop, rsp_id=0, empty=4'b1111.
REQ-042 Fill 8 entries over q1/q2 -> push_rdy=0; ninth push dropped; pop q1 then push -> accepted, reuses freed index.
REQ-043 Pop q3 while empty -> pop_err pulse 1 cycle, rsp_vld=0, free_cnt unchanged.
REQ-044 q2 holds 0x5; same-cycle push q2 0x6 + pop q2 -> rsp 0x5; next pop q2 -> 0x6, then empty[2]=1.
REQ-045 Assert rst_n=0 with 5 entries queued -> next cycle free_cnt=8, empty=4'b1111, rsp_vld=0.
